// File: rtl/fetch_ctrl_pkg.sv
// Shared types and constants for the instruction-fetch sequencer.
package fetch_pkg;

  // Fetch sequencer states; at most one fetch is ever outstanding.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    DROP = 2'd3
  } fetch_state_t;

  // Byte distance between sequential instructions.
  localparam int unsigned PC_INCR = 4;

  // Width of the redirect target bus coming from branch resolution.
  localparam int unsigned BR_W = 32;

endpackage : fetch_pkg

// File: rtl/fetch_ctrl_if.sv
// Instruction-memory request/response handshake between fetch and imem.
interface fetch_ctrl_if #(
  parameter int unsigned PC_W = 9
);

  logic            Imem_Req;
  logic [PC_W-1:0] Imem_Addr;
  logic            Imem_Gnt;
  logic            Imem_Rvalid;
  logic            Imem_Rready;

  // Fetch side drives the address channel and the read-data ready.
  modport master (
    output Imem_Req,
    output Imem_Addr,
    output Imem_Rready,
    input  Imem_Gnt,
    input  Imem_Rvalid
  );

  // Memory side answers with grant and read-data valid.
  modport slave (
    input  Imem_Req,
    input  Imem_Addr,
    input  Imem_Rready,
    output Imem_Gnt,
    output Imem_Rvalid
  );

endinterface : fetch_ctrl_if

// File: rtl/fetch_ctrl.sv
// Instruction-fetch sequencer: owns the PC, drives the imem handshake,
// applies branch redirects with pipeline flushes and drops wrong-path data.
module fetch_ctrl
  import fetch_pkg::*;
#(
  parameter int unsigned     PC_W     = 9,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              Stall,
  input  logic              PcSel,
  input  logic [BR_W-1:0]   BrPC,
  fetch_ctrl_if.master      imem,
  output logic              Instr_Valid,
  output logic [PC_W-1:0]   Instr_PC,
  output logic              Flush_IFID,
  output logic              Flush_IDEX,
  output logic              Target_Err
);

  fetch_state_t    state_q, state_d;
  logic [PC_W-1:0] pc_q, pc_d;
  logic            terr_q, terr_d;

  logic            redirect;
  logic            bad_tgt;
  logic            rsp_accept;
  logic [PC_W-1:0] redirect_tgt;
  logic [PC_W-1:0] pc_inc;

  logic            req_c;
  logic            rready_c;
  logic            ivalid_c;
  logic            flush_c;

  // Redirect decode: target is word-aligned, out-of-range or misaligned
  // targets are still followed but flagged.
  always_comb begin
    redirect     = PcSel && (state_q != IDLE);
    redirect_tgt = {BrPC[PC_W-1:2], 2'b00};
    bad_tgt      = (BrPC[1:0] != 2'b00) || (BrPC[BR_W-1:PC_W] != '0);
    pc_inc       = pc_q + PC_W'(PC_INCR);
  end

  // State, PC and sticky error registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      pc_q    <= RESET_PC;
      terr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      terr_q  <= terr_d;
    end
  end

  // Next-state, next-PC mux and handshake outputs.
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    terr_d     = terr_q;
    req_c      = 1'b0;
    rready_c   = 1'b0;
    ivalid_c   = 1'b0;
    flush_c    = 1'b0;
    rsp_accept = 1'b0;

    if (redirect) begin
      flush_c = 1'b1;
      if (bad_tgt) begin
        terr_d = 1'b1;
      end
    end

    unique case (state_q)
      IDLE: begin
        state_d = REQ;
      end

      REQ: begin
        req_c = 1'b1;
        if (redirect) begin
          pc_d    = redirect_tgt;
          // A fetch granted alongside the redirect is already stale.
          state_d = imem.Imem_Gnt ? DROP : REQ;
        end else if (imem.Imem_Gnt) begin
          state_d = WAIT;
        end
      end

      WAIT: begin
        rready_c   = !Stall;
        rsp_accept = imem.Imem_Rvalid && !Stall;
        if (redirect) begin
          pc_d    = redirect_tgt;
          // Response still in flight must be swallowed before refetching.
          state_d = rsp_accept ? REQ : DROP;
        end else if (rsp_accept) begin
          ivalid_c = 1'b1;
          pc_d     = pc_inc;
          state_d  = REQ;
        end
      end

      DROP: begin
        rready_c = 1'b1;
        if (redirect) begin
          pc_d = redirect_tgt;
        end
        if (imem.Imem_Rvalid) begin
          state_d = REQ;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Output drive; the fetch address always tracks the PC register.
  assign imem.Imem_Req    = req_c;
  assign imem.Imem_Addr   = pc_q;
  assign imem.Imem_Rready = rready_c;
  assign Instr_Valid      = ivalid_c;
  assign Instr_PC         = ivalid_c ? pc_q : '0;
  assign Flush_IFID       = flush_c;
  assign Flush_IDEX       = flush_c;
  assign Target_Err       = terr_q;

endmodule : fetch_ctrl

// File: tb/tb_fetch_ctrl.sv
// Directed self-checking bench for fetch_ctrl.
module tb_fetch_ctrl;

  logic       clk;
  logic       reset;
  logic       Stall;
  logic       PcSel;
  logic [31:0] BrPC;
  logic       Instr_Valid;
  logic [8:0] Instr_PC;
  logic       Flush_IFID;
  logic       Flush_IDEX;
  logic       Target_Err;

  int n_cmp;
  int n_err;

  fetch_ctrl_if #(.PC_W(9)) imem ();

  fetch_ctrl #(.PC_W(9), .RESET_PC(9'h000)) dut (
    .clk         (clk),
    .reset       (reset),
    .Stall       (Stall),
    .PcSel       (PcSel),
    .BrPC        (BrPC),
    .imem        (imem),
    .Instr_Valid (Instr_Valid),
    .Instr_PC    (Instr_PC),
    .Flush_IFID  (Flush_IFID),
    .Flush_IDEX  (Flush_IDEX),
    .Target_Err  (Target_Err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clr_inputs();
    Stall            = 1'b0;
    PcSel            = 1'b0;
    BrPC             = 32'h0;
    imem.Imem_Gnt    = 1'b0;
    imem.Imem_Rvalid = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    clr_inputs();
    #3;
    n_cmp++;
    if ({imem.Imem_Req, imem.Imem_Rready, Instr_Valid, Flush_IFID, Flush_IDEX, Target_Err} !== 6'b0) begin
      n_err++;
      $display("FAIL reset_outs: got %b want 000000",
               {imem.Imem_Req, imem.Imem_Rready, Instr_Valid, Flush_IFID, Flush_IDEX, Target_Err});
    end
    n_cmp++;
    if (imem.Imem_Addr !== 9'h000) begin
      n_err++; $display("FAIL reset_addr: got %h want 000", imem.Imem_Addr);
    end
    tick();
    reset = 1'b0;
    // first cycle out of reset is IDLE: a redirect must not flush here
    PcSel = 1'b1; BrPC = 32'h40;
    #1;
    n_cmp++;
    if ({imem.Imem_Req, imem.Imem_Rready, Flush_IFID, Flush_IDEX} !== 4'b0) begin
      n_err++;
      $display("FAIL idle_outs: got %b want 0000",
               {imem.Imem_Req, imem.Imem_Rready, Flush_IFID, Flush_IDEX});
    end
    PcSel = 1'b0; BrPC = 32'h0;
    tick();
    n_cmp++;
    if ({imem.Imem_Req, imem.Imem_Addr} !== {1'b1, 9'h000}) begin
      n_err++; $display("FAIL first_req: got req=%b addr=%h want req=1 addr=000", imem.Imem_Req, imem.Imem_Addr);
    end
  endtask

  task automatic test_free_run();
    logic [8:0] exp_pc;
    for (int i = 0; i < 4; i++) begin
      exp_pc = 9'(i * 4);
      imem.Imem_Gnt = 1'b1;
      #1;
      n_cmp++;
      if ({imem.Imem_Req, Instr_Valid, imem.Imem_Addr} !== {1'b1, 1'b0, exp_pc}) begin
        n_err++;
        $display("FAIL run_req%0d: got req=%b iv=%b addr=%h want req=1 iv=0 addr=%h",
                 i, imem.Imem_Req, Instr_Valid, imem.Imem_Addr, exp_pc);
      end
      tick();
      imem.Imem_Gnt = 1'b0; imem.Imem_Rvalid = 1'b1;
      #1;
      n_cmp++;
      if ({imem.Imem_Req, imem.Imem_Rready, Instr_Valid, Instr_PC} !== {1'b0, 1'b1, 1'b1, exp_pc}) begin
        n_err++;
        $display("FAIL run_rsp%0d: got req=%b rr=%b iv=%b ipc=%h want 0 1 1 %h",
                 i, imem.Imem_Req, imem.Imem_Rready, Instr_Valid, Instr_PC, exp_pc);
      end
      tick();
      imem.Imem_Rvalid = 1'b0;
    end
  endtask

  task automatic test_stall();
    // REQ at PC 0x010
    imem.Imem_Gnt = 1'b1;
    tick();
    imem.Imem_Gnt = 1'b0;
    for (int i = 0; i < 3; i++) begin
      Stall = 1'b1; imem.Imem_Rvalid = 1'b1;
      #1;
      n_cmp++;
      if ({imem.Imem_Rready, Instr_Valid} !== 2'b00) begin
        n_err++;
        $display("FAIL stall%0d: got rr=%b iv=%b want rr=0 iv=0", i, imem.Imem_Rready, Instr_Valid);
      end
      tick();
    end
    Stall = 1'b0;
    #1;
    n_cmp++;
    if ({imem.Imem_Rready, Instr_Valid, Instr_PC} !== {1'b1, 1'b1, 9'h010}) begin
      n_err++;
      $display("FAIL stall_release: got rr=%b iv=%b ipc=%h want 1 1 010",
               imem.Imem_Rready, Instr_Valid, Instr_PC);
    end
    tick();
    imem.Imem_Rvalid = 1'b0;
    #1;
    n_cmp++;
    if ({imem.Imem_Req, imem.Imem_Addr} !== {1'b1, 9'h014}) begin
      n_err++; $display("FAIL stall_next: got req=%b addr=%h want 1 014", imem.Imem_Req, imem.Imem_Addr);
    end
  endtask

  task automatic test_redirect_wait();
    imem.Imem_Gnt = 1'b1;
    tick();
    imem.Imem_Gnt = 1'b0;
    PcSel = 1'b1; BrPC = 32'h40;
    #1;
    n_cmp++;
    if ({Flush_IFID, Flush_IDEX, Instr_Valid} !== 3'b110) begin
      n_err++;
      $display("FAIL rw_flush: got fi=%b fd=%b iv=%b want 1 1 0", Flush_IFID, Flush_IDEX, Instr_Valid);
    end
    tick();
    PcSel = 1'b0; BrPC = 32'h0; Stall = 1'b1;
    #1;
    // DROP: ready even under stall, no request, PC already at target
    n_cmp++;
    if ({imem.Imem_Req, imem.Imem_Rready, Flush_IFID, imem.Imem_Addr} !== {1'b0, 1'b1, 1'b0, 9'h040}) begin
      n_err++;
      $display("FAIL rw_drop: got req=%b rr=%b fi=%b addr=%h want 0 1 0 040",
               imem.Imem_Req, imem.Imem_Rready, Flush_IFID, imem.Imem_Addr);
    end
    tick();
    imem.Imem_Rvalid = 1'b1;
    #1;
    n_cmp++;
    if ({imem.Imem_Rready, Instr_Valid} !== 2'b10) begin
      n_err++;
      $display("FAIL rw_swallow: got rr=%b iv=%b want 1 0", imem.Imem_Rready, Instr_Valid);
    end
    tick();
    imem.Imem_Rvalid = 1'b0; Stall = 1'b0;
    #1;
    n_cmp++;
    if ({imem.Imem_Req, imem.Imem_Addr} !== {1'b1, 9'h040}) begin
      n_err++; $display("FAIL rw_refetch: got req=%b addr=%h want 1 040", imem.Imem_Req, imem.Imem_Addr);
    end
  endtask

  task automatic test_redirect_gnt();
    imem.Imem_Gnt = 1'b1; PcSel = 1'b1; BrPC = 32'h80;
    #1;
    n_cmp++;
    if ({Flush_IFID, Flush_IDEX} !== 2'b11) begin
      n_err++; $display("FAIL rg_flush: got %b want 11", {Flush_IFID, Flush_IDEX});
    end
    tick();
    imem.Imem_Gnt = 1'b0; PcSel = 1'b0; BrPC = 32'h0;
    #1;
    n_cmp++;
    if ({imem.Imem_Req, imem.Imem_Rready, imem.Imem_Addr} !== {1'b0, 1'b1, 9'h080}) begin
      n_err++;
      $display("FAIL rg_drop: got req=%b rr=%b addr=%h want 0 1 080",
               imem.Imem_Req, imem.Imem_Rready, imem.Imem_Addr);
    end
    tick();
    imem.Imem_Rvalid = 1'b1;
    #1;
    n_cmp++;
    if (Instr_Valid !== 1'b0) begin
      n_err++; $display("FAIL rg_swallow: got iv=%b want 0", Instr_Valid);
    end
    tick();
    imem.Imem_Rvalid = 1'b0; imem.Imem_Gnt = 1'b1;
    #1;
    n_cmp++;
    if ({imem.Imem_Req, imem.Imem_Addr} !== {1'b1, 9'h080}) begin
      n_err++; $display("FAIL rg_refetch: got req=%b addr=%h want 1 080", imem.Imem_Req, imem.Imem_Addr);
    end
    tick();
    imem.Imem_Gnt = 1'b0; imem.Imem_Rvalid = 1'b1;
    #1;
    // only the one stale response is dropped; this one is delivered
    n_cmp++;
    if ({Instr_Valid, Instr_PC} !== {1'b1, 9'h080}) begin
      n_err++; $display("FAIL rg_deliver: got iv=%b ipc=%h want 1 080", Instr_Valid, Instr_PC);
    end
    tick();
    imem.Imem_Rvalid = 1'b0;
    // redirect in REQ without grant stays in REQ at the new target
    PcSel = 1'b1; BrPC = 32'h100;
    tick();
    PcSel = 1'b0; BrPC = 32'h0;
    #1;
    n_cmp++;
    if ({imem.Imem_Req, imem.Imem_Addr, Target_Err} !== {1'b1, 9'h100, 1'b0}) begin
      n_err++;
      $display("FAIL rg_nognt: got req=%b addr=%h terr=%b want 1 100 0",
               imem.Imem_Req, imem.Imem_Addr, Target_Err);
    end
  endtask

  task automatic test_target_err();
    PcSel = 1'b1; BrPC = 32'h1F2;
    tick();
    PcSel = 1'b0; BrPC = 32'h0;
    #1;
    n_cmp++;
    if ({imem.Imem_Addr, Target_Err} !== {9'h1F0, 1'b1}) begin
      n_err++; $display("FAIL terr_set: got addr=%h terr=%b want 1f0 1", imem.Imem_Addr, Target_Err);
    end
    tick(); tick();
    n_cmp++;
    if (Target_Err !== 1'b1) begin
      n_err++; $display("FAIL terr_sticky: got %b want 1", Target_Err);
    end
  endtask

  task automatic test_wrap();
    PcSel = 1'b1; BrPC = 32'h1FC;
    tick();
    PcSel = 1'b0; BrPC = 32'h0; imem.Imem_Gnt = 1'b1;
    tick();
    imem.Imem_Gnt = 1'b0; imem.Imem_Rvalid = 1'b1;
    #1;
    n_cmp++;
    if ({Instr_Valid, Instr_PC} !== {1'b1, 9'h1FC}) begin
      n_err++; $display("FAIL wrap_deliver: got iv=%b ipc=%h want 1 1fc", Instr_Valid, Instr_PC);
    end
    tick();
    imem.Imem_Rvalid = 1'b0;
    #1;
    n_cmp++;
    if ({imem.Imem_Req, imem.Imem_Addr} !== {1'b1, 9'h000}) begin
      n_err++; $display("FAIL wrap_pc: got req=%b addr=%h want 1 000", imem.Imem_Req, imem.Imem_Addr);
    end
  endtask

  task automatic test_reset_in_drop();
    imem.Imem_Gnt = 1'b1; PcSel = 1'b1; BrPC = 32'h20;
    tick();
    clr_inputs();
    #1;
    n_cmp++;
    if ({imem.Imem_Rready, imem.Imem_Addr} !== {1'b1, 9'h020}) begin
      n_err++; $display("FAIL rd_indrop: got rr=%b addr=%h want 1 020", imem.Imem_Rready, imem.Imem_Addr);
    end
    #1;
    reset = 1'b1;
    #1;
    n_cmp++;
    if ({imem.Imem_Req, imem.Imem_Rready, Target_Err, imem.Imem_Addr} !== {3'b000, 9'h000}) begin
      n_err++;
      $display("FAIL rd_async: got req=%b rr=%b terr=%b addr=%h want 0 0 0 000",
               imem.Imem_Req, imem.Imem_Rready, Target_Err, imem.Imem_Addr);
    end
    tick();
    reset = 1'b0;
    tick();
    n_cmp++;
    if ({imem.Imem_Req, imem.Imem_Addr} !== {1'b1, 9'h000}) begin
      n_err++; $display("FAIL rd_restart: got req=%b addr=%h want 1 000", imem.Imem_Req, imem.Imem_Addr);
    end
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    test_reset();
    test_free_run();
    test_stall();
    test_redirect_wait();
    test_redirect_gnt();
    test_target_err();
    test_wrap();
    test_reset_in_drop();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule : tb_fetch_ctrl

// File: doc/fetch_ctrl.md
# fetch_ctrl

Instruction-fetch sequencer that owns the program counter and drives the instruction-memory request/response handshake. It consumes the branch-resolution outputs (`PcSel`, `BrPC`) and the hazard stall. It also generates the pipeline flushes for a taken branch or jump. It sits between the EX-stage branch logic, the hazard unit and instruction memory, and it discards wrong-path responses when a redirect overtakes an outstanding fetch.

## Interface
Parameters:
- `PC_W`, 9: PC width in bits; PC arithmetic is modulo 2^PC_W.
- `RESET_PC`, 0: PC value loaded on reset; must be word-aligned.

Ports:
- `clk`  in  1  single clock; all state updates on the rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `Stall`  in  1  hazard stall; 1 means IF/ID cannot accept an instruction this cycle.
- `PcSel`  in  1  redirect request from branch resolution (taken branch/jal/jalr).
- `BrPC`  in  32  redirect target; valid when `PcSel`=1.
- `Imem_Req`  out  1  address-channel valid.
- `Imem_Addr`  out  PC_W  fetch address; always equals `PC`.
- `Imem_Gnt`  in  1  address accepted; effective only while `Imem_Req`=1.
- `Imem_Rvalid`  in  1  read data valid.
- `Imem_Rready`  out  1  read data accepted.
- `Instr_Valid`  out  1  memory read data is a correct-path instruction to be written into IF/ID.
- `Instr_PC`  out  PC_W  address of the instruction flagged by `Instr_Valid`.
- `Flush_IFID`  out  1  clear the IF/ID register at the next edge.
- `Flush_IDEX`  out  1  clear the ID/EX register at the next edge.
- `Target_Err`  out  1  sticky flag for an illegal redirect target.

## Operation
- FSM states: IDLE, REQ, WAIT, DROP. At most one fetch is outstanding.
- IDLE: occupied only in the first cycle after reset. All outputs are 0 except `Imem_Addr`=`RESET_PC`. Moves to REQ unconditionally.
- REQ: `Imem_Req`=1.
  - On `Imem_Gnt` with no redirect, moves to WAIT.
  - On redirect without `Imem_Gnt`: PC<=target; stays in REQ.
  - On redirect together with `Imem_Gnt`: PC<=target; moves to DROP, because the granted fetch is stale.
- WAIT: `Imem_Req`=0, `Imem_Rready`=!`Stall`.
  - On `Imem_Rvalid`&`Imem_Rready` with no redirect: `Instr_Valid`=1, `Instr_PC`=PC, PC<=PC+4, moves to REQ.
  - On redirect with `Imem_Rvalid`&`Imem_Rready`: the response is discarded (`Instr_Valid`=0), PC<=target, moves to REQ.
  - On redirect without an accepted response: PC<=target, moves to DROP.
- DROP: `Imem_Req`=0, `Imem_Rready`=1 regardless of `Stall`, `Instr_Valid`=0.
  - On `Imem_Rvalid`, moves to REQ.
  - A further redirect updates PC; the state stays DROP.
- Redirect target = `BrPC[PC_W-1:0]` with bits [1:0] forced to 0.
- Redirect priority: `PcSel` overrides `Stall` in every state.
- `Flush_IFID`=`Flush_IDEX`=`PcSel`, combinational, in every state except IDLE.
- `Target_Err` is set when `PcSel`=1 and either `BrPC[1:0]`≠0 or `BrPC[31:PC_W]`≠0. It is cleared only by reset.
- PC+4 wraps to 0 past 2^PC_W−4.

## Timing
- Reset values: state IDLE, PC=`RESET_PC`, `Target_Err`=0; all handshake outputs, `Instr_Valid` and flushes are 0.
- Reset mid-operation returns to IDLE immediately. Instruction memory shares `reset`, so no response from before reset arrives afterwards.
- Best-case throughput is one instruction per 2 cycles: REQ with `Gnt`, then WAIT with `Rvalid`.
- A redirect in cycle N makes `Imem_Addr` equal to the target from cycle N+1.
- `Flush_*` have zero latency: they are asserted in the same cycle as `PcSel`.
- `Instr_Valid` is combinational from `Imem_Rvalid`, `Stall`, `PcSel` and state. It is never asserted in IDLE, REQ or DROP.

## Structure
- Shared package (`fetch_pkg`):
  - `fetch_state_t` enum: IDLE, REQ, WAIT, DROP.
  - `PC_INCR` = 4.
- Single module. The next-PC mux (PC+4, redirect target, hold) is an internal combinational block; no sub-module is required.

## Test plan
- Reset then free run with `Gnt` and `Rvalid` each asserted one cycle after the request → `Instr_PC` sequence 0, 4, 8, 12; `Instr_Valid` every second cycle.
- `Stall`=1 for 3 cycles while in WAIT with `Rvalid` held → `Imem_Rready`=0 and no `Instr_Valid` for 3 cycles; the instruction is delivered on the first non-stall cycle with an unchanged PC.
- `PcSel`=1, `BrPC`=0x40 in WAIT before `Rvalid` → both flushes pulse, state goes to DROP, the late response is swallowed with `Instr_Valid`=0, and the next `Imem_Addr`=0x40.
- `PcSel` in the same cycle as `Imem_Gnt` in REQ → moves to DROP and exactly one response is discarded.
- `BrPC`=0x1F2 with `PC_W`=9 → the new PC is 0x1F0 and `Target_Err`=1, staying set until reset.
- Reset asserted in DROP → IDLE and PC=`RESET_PC` immediately, without waiting for a clock edge.
- PC=0x1FC with no redirect → the next PC is 0x000.
